cla28_pipe_sum: RTL and testbench

CLA28_PIPE_SUM -- requirements
Module: cla28_pipe_sum

---
 rtl/cla_pkg.sv | 13 +
 rtl/pg_group4.sv | 16 +
 rtl/cla28_pipe_sum.sv | 121 ++++++++++++
 tb/tb_cla28_pipe_sum.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and types for the 28-bit pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned WIDTH = 28;
  localparam int unsigned GRP   = 4;
  localparam int unsigned NGRP  = 7;

  typedef struct packed {
    logic gp;
    logic gg;
  } grp_pg_t;

endpackage

// File: rtl/pg_group4.sv
// Bit and group propagate/generate terms for one 4-bit lookahead slice.
module pg_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p,
  output logic [3:0] g,
  output logic       gp,
  output logic       gg
);

  assign p  = a ^ b;
  assign g  = a & b;
  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla28_pipe_sum.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake on both sides.
module cla28_pipe_sum #(
  parameter int unsigned WIDTH = cla_pkg::WIDTH,
  parameter int unsigned GRP   = cla_pkg::GRP,
  parameter int unsigned NGRP  = cla_pkg::NGRP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  import cla_pkg::*;

  logic                  load1, load2;
  logic                  v1, v2;
  logic [WIDTH-1:0]      p_w, g_w, p1, g1;
  grp_pg_t [NGRP-1:0]    grp_w, grp1;
  logic                  cin1;

  logic [NGRP:0]         cg;
  logic [WIDTH-1:0]      c;
  logic                  term, acc;
  logic                  unused_gtop;

  assign load2     = !v2 || out_ready;
  assign load1     = !v1 || load2;
  assign in_ready  = load1;
  assign out_valid = v2;

  for (genvar i = 0; i < NGRP; i++) begin : gen_pg
    logic gp_i, gg_i;
    pg_group4 u_pg (
      .a  (A[i*GRP +: GRP]),
      .b  (B[i*GRP +: GRP]),
      .p  (p_w[i*GRP +: GRP]),
      .g  (g_w[i*GRP +: GRP]),
      .gp (gp_i),
      .gg (gg_i)
    );
    assign grp_w[i] = '{gp: gp_i, gg: gg_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      p1   <= '0;
      g1   <= '0;
      grp1 <= '0;
      cin1 <= 1'b0;
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        p1   <= p_w;
        g1   <= g_w;
        grp1 <= grp_w;
        cin1 <= cin;
      end
    end
  end

  // Each group carry is a flat sum-of-products over all lower groups, so no
  // carry ripples from one group to the next.
  always_comb begin
    cg    = '0;
    term  = 1'b0;
    acc   = 1'b0;
    cg[0] = cin1;
    for (int unsigned k = 0; k < NGRP; k++) begin
      term = cin1;
      for (int unsigned j = 0; j <= k; j++) term = term & grp1[j].gp;
      acc = term;
      for (int unsigned j = 0; j <= k; j++) begin
        term = grp1[j].gg;
        for (int unsigned m = j + 1; m <= k; m++) term = term & grp1[m].gp;
        acc = acc | term;
      end
      cg[k+1] = acc;
    end
  end

  always_comb begin
    c = '0;
    for (int unsigned k = 0; k < NGRP; k++) begin
      c[k*GRP] = cg[k];
      for (int unsigned j = 0; j + 1 < GRP; j++) begin
        c[k*GRP+j+1] = g1[k*GRP+j] | (p1[k*GRP+j] & c[k*GRP+j]);
      end
    end
  end

  // Top generate bit of each group is already folded into its group generate.
  always_comb begin
    unused_gtop = 1'b0;
    for (int unsigned k = 0; k < NGRP; k++) unused_gtop = unused_gtop ^ g1[k*GRP+GRP-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      S    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        S    <= p1 ^ c;
        cout <= cg[NGRP];
        ovf  <= c[WIDTH-1] ^ cg[NGRP];
      end
    end
  end

endmodule

// File: tb/tb_cla28_pipe_sum.sv
// Directed bench for cla28_pipe_sum: corner sums, backpressured stream, mid-flight reset.
module tb_cla28_pipe_sum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] a, b, s;
  logic        cin, in_valid, in_ready, cout, ovf, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla28_pipe_sum u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result packed as {ovf, cout, sum}.
  function automatic logic [29:0] model(input logic [27:0] x, input logic [27:0] y,
                                        input logic ci);
    logic [28:0] sum;
    logic        v;
    sum = {1'b0, x} + {1'b0, y} + {28'd0, ci};
    v   = (x[27] == y[27]) && (sum[27] != x[27]);
    return {v, sum};
  endfunction

  // Called one time unit after a rising edge, pipeline empty, out_ready high.
  task automatic single(input string tag, input logic [27:0] av, input logic [27:0] bv,
                        input logic ci, input logic [27:0] es, input logic ec,
                        input logic eo);
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, ".lat1_valid"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, ".lat2_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".sum"}, {4'd0, s}, {4'd0, es});
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    step();
    chk({tag, ".drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [29:0] expq[$];
  logic [27:0] ra[10], rb[10];
  logic        rc[10];
  logic [29:0] hv, exp_v;
  logic        held;
  int          sent, got, lowready;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 28'h1234567; b = 28'h0000001; cin = 1'b0;
    #2;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.sum", {4'd0, s}, 32'd0);
    chk("rst.cout_ovf", {30'd0, cout, ovf}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst.ignored1", {31'd0, out_valid}, 32'd0);
    step();
    chk("rst.ignored2", {31'd0, out_valid}, 32'd0);

    single("v_0ffffff", 28'h0FFFFFF, 28'h0000001, 1'b0, 28'h1000000, 1'b0, 1'b0);
    single("v_fullchain", 28'hFFFFFFF, 28'h0000000, 1'b1, 28'h0000000, 1'b1, 1'b0);
    single("v_posovf", 28'h7FFFFFF, 28'h0000001, 1'b0, 28'h8000000, 1'b0, 1'b1);
    single("v_negovf", 28'h8000000, 28'h8000000, 1'b0, 28'h0000000, 1'b1, 1'b1);
    single("v_alt", 28'hA5A5A5A, 28'h5A5A5A5, 1'b1, 28'h0000000, 1'b1, 1'b0);
    single("v_plain", 28'h1234567, 28'h0FEDCBA, 1'b0, 28'h2222221, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ra[i] = 28'($urandom);
      rb[i] = 28'($urandom);
      rc[i] = 1'($urandom);
    end
    sent = 0; got = 0; lowready = 0; held = 1'b0; hv = '0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 10);
      if (sent < 10) begin
        a = ra[sent]; b = rb[sent]; cin = rc[sent];
      end
      #1;
      if (held) begin
        chk("stream.hold_valid", {31'd0, out_valid}, 32'd1);
        chk("stream.hold_data", {2'd0, ovf, cout, s}, {2'd0, hv});
      end
      if (!in_ready) lowready++;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("stream.extra", 32'd1, 32'd0);
        end else begin
          exp_v = expq.pop_front();
          chk("stream.result", {2'd0, ovf, cout, s}, {2'd0, exp_v});
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(ra[sent], rb[sent], rc[sent]));
        sent++;
      end
      held = out_valid && !out_ready;
      hv   = {ovf, cout, s};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream.count", got, 32'd10);
    chk("stream.leftover", expq.size(), 32'd0);
    chk("stream.stall_cycles", lowready, 32'd4);
    step();

    out_ready = 1'b0;
    a = 28'h0000010; b = 28'h0000020; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 28'h0000003; b = 28'h0000004;
    step();
    in_valid = 1'b0;
    #1;
    chk("midrst.full_valid", {31'd0, out_valid}, 32'd1);
    chk("midrst.full_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid_drop", {31'd0, out_valid}, 32'd0);
    chk("midrst.sum_clear", {4'd0, s}, 32'd0);
    chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("midrst.no_stale1", {31'd0, out_valid}, 32'd0);
    step();
    chk("midrst.no_stale2", {31'd0, out_valid}, 32'd0);
    single("post_rst", 28'h1111111, 28'h2222222, 1'b1, 28'h3333334, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
